// File: rtl/alu_ctrl_issue_pkg.sv
// Shared definitions for the ALU opcode issue path.
//  - ALU opcode encodings driven onto the ALU opcode input
//  - RV32I major opcode constants used by the decoder
//  - alu_issue_t: the decoded payload carried through the skid buffer
package alu_pkg;

  localparam logic [2:0] ALU_NONE = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_SUB  = 3'b010;
  localparam logic [2:0] ALU_AND  = 3'b011;
  localparam logic [2:0] ALU_OR   = 3'b100;
  localparam logic [2:0] ALU_SLL  = 3'b101;
  localparam logic [2:0] ALU_SRL  = 3'b110;

  localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef struct packed {
    logic [2:0] opcode;
    logic       op2_imm;
    logic       is_branch;
    logic       illegal;
  } alu_issue_t;

endpackage

// File: rtl/alu_ctrl_issue_if.sv
// Handshake bundle between fetch/decode, this issue block and the execute stage.
//  master : the issue block (accepts instr, produces the decoded op)
//  slave  : the surrounding environment (supplies instr, consumes the op)
//  in_valid/in_ready/instr          : instruction side handshake
//  out_valid/out_ready              : issued-op side handshake
//  alu_opcode/op2_imm/is_branch/illegal : issued op payload
//  illegal_cnt                      : saturating count of issued illegal ops
interface alu_ctrl_issue_if #(
  parameter int unsigned CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      instr;
  logic             out_valid;
  logic             out_ready;
  logic [2:0]       alu_opcode;
  logic             op2_imm;
  logic             is_branch;
  logic             illegal;
  logic [CNT_W-1:0] illegal_cnt;

  modport master (
    input  in_valid, instr, out_ready,
    output in_ready, out_valid, alu_opcode, op2_imm, is_branch, illegal, illegal_cnt
  );

  modport slave (
    output in_valid, instr, out_ready,
    input  in_ready, out_valid, alu_opcode, op2_imm, is_branch, illegal, illegal_cnt
  );
endinterface

// File: rtl/alu_ctrl_issue_skid.sv
// alu_skid_buffer: 2-entry registered valid/ready stage (output reg + skid entry).
//  clk, rst  : clock, synchronous active-high reset
//  i_valid   : upstream valid        o_ready : upstream ready (flops and rst only)
//  i_data    : upstream payload
//  o_valid   : downstream valid      i_ready : downstream ready
//  o_data    : downstream payload (registered)
module alu_skid_buffer
  import alu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_valid,
  output logic       o_ready,
  input  alu_issue_t i_data,
  output logic       o_valid,
  input  logic       i_ready,
  output alu_issue_t o_data
);

  logic       r_out_valid;
  alu_issue_t r_out_data;
  logic       r_skid_valid;
  alu_issue_t r_skid_data;
  logic       w_in_xfer;
  logic       w_out_xfer;

  assign o_ready    = !r_skid_valid && !rst;
  assign w_in_xfer  = i_valid && o_ready;
  assign w_out_xfer = r_out_valid && i_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_skid_valid <= 1'b0;
      r_skid_data  <= '0;
    end else if (!r_out_valid || w_out_xfer) begin
      // Output slot frees up: the skid entry (older) has priority. When the
      // skid is full o_ready was low, so no new transfer competes with it.
      if (r_skid_valid) begin
        r_out_data   <= r_skid_data;
        r_out_valid  <= 1'b1;
        r_skid_valid <= 1'b0;
      end else if (w_in_xfer) begin
        r_out_data  <= i_data;
        r_out_valid <= 1'b1;
      end else begin
        r_out_valid <= 1'b0;
      end
    end else if (w_in_xfer) begin
      r_skid_data  <= i_data;
      r_skid_valid <= 1'b1;
    end
  end

  assign o_valid = r_out_valid;
  assign o_data  = r_out_data;

endmodule

// File: rtl/alu_ctrl_issue.sv
// alu_ctrl_issue: decodes RV32I instruction words into ALU opcode / operand-2
// select / branch flag and issues them through a 2-entry skid buffer.
// Unsupported functions are issued as illegal with opcode ALU_NONE.
//  clk, rst : clock, synchronous active-high reset
//  bus      : alu_ctrl_issue_if.master (instr in, decoded op out, illegal_cnt)
//  CNT_W    : illegal_cnt width
// Optional feature: define ALU_ILLEGAL_CNT_EN to enable the saturating
// illegal-op counter; otherwise illegal_cnt is tied to 0.
module alu_ctrl_issue
  import alu_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  alu_ctrl_issue_if.master    bus
);

  function automatic alu_issue_t f_legal(input logic [2:0] i_op, input logic i_imm,
                                         input logic i_br);
    alu_issue_t v;
    v.opcode    = i_op;
    v.op2_imm   = i_imm;
    v.is_branch = i_br;
    v.illegal   = 1'b0;
    return v;
  endfunction

  function automatic alu_issue_t f_decode(input logic [31:0] i_instr);
    logic [6:0] v_opc;
    logic [2:0] v_f3;
    logic [6:0] v_f7;
    alu_issue_t v_d;
    v_opc = i_instr[6:0];
    v_f3  = i_instr[14:12];
    v_f7  = i_instr[31:25];
    v_d         = '0;
    v_d.illegal = 1'b1;
    case (v_opc)
      OPC_RTYPE: begin
        case (v_f3)
          3'b000: begin
            if (v_f7 == 7'h00)      v_d = f_legal(ALU_ADD, 1'b0, 1'b0);
            else if (v_f7 == 7'h20) v_d = f_legal(ALU_SUB, 1'b0, 1'b0);
          end
          3'b111: if (v_f7 == 7'h00) v_d = f_legal(ALU_AND, 1'b0, 1'b0);
          3'b110: if (v_f7 == 7'h00) v_d = f_legal(ALU_OR,  1'b0, 1'b0);
          3'b001: if (v_f7 == 7'h00) v_d = f_legal(ALU_SLL, 1'b0, 1'b0);
          3'b101: if (v_f7 == 7'h00) v_d = f_legal(ALU_SRL, 1'b0, 1'b0);
          default: ;
        endcase
      end
      OPC_ITYPE: begin
        case (v_f3)
          3'b000: v_d = f_legal(ALU_ADD, 1'b1, 1'b0);
          3'b111: v_d = f_legal(ALU_AND, 1'b1, 1'b0);
          3'b110: v_d = f_legal(ALU_OR,  1'b1, 1'b0);
          3'b001: if (v_f7 == 7'h00) v_d = f_legal(ALU_SLL, 1'b1, 1'b0);
          3'b101: if (v_f7 == 7'h00) v_d = f_legal(ALU_SRL, 1'b1, 1'b0);
          default: ;
        endcase
      end
      OPC_LOAD, OPC_STORE: v_d = f_legal(ALU_ADD, 1'b1, 1'b0);
      OPC_BRANCH: begin
        if (v_f3 == 3'b000 || v_f3 == 3'b001) v_d = f_legal(ALU_SUB, 1'b0, 1'b1);
      end
      default: ;
    endcase
    return v_d;
  endfunction

  alu_issue_t w_dec;
  alu_issue_t w_out;
  logic       w_out_valid;
  logic       w_in_ready;

  assign w_dec = f_decode(bus.instr);

  alu_skid_buffer u_skid (
    .clk     (clk),
    .rst     (rst),
    .i_valid (bus.in_valid),
    .o_ready (w_in_ready),
    .i_data  (w_dec),
    .o_valid (w_out_valid),
    .i_ready (bus.out_ready),
    .o_data  (w_out)
  );

  assign bus.in_ready   = w_in_ready;
  assign bus.out_valid  = w_out_valid;
  assign bus.alu_opcode = w_out.opcode;
  assign bus.op2_imm    = w_out.op2_imm;
  assign bus.is_branch  = w_out.is_branch;
  assign bus.illegal    = w_out.illegal;

`ifdef ALU_ILLEGAL_CNT_EN
  logic [CNT_W-1:0] r_illegal_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_illegal_cnt <= '0;
    end else if (w_out_valid && bus.out_ready && w_out.illegal && (r_illegal_cnt != '1)) begin
      r_illegal_cnt <= r_illegal_cnt + CNT_W'(1);
    end
  end

  assign bus.illegal_cnt = r_illegal_cnt;
`else
  assign bus.illegal_cnt = '0;
`endif

endmodule

// File: tb/tb_alu_ctrl_issue.sv
module tb_alu_ctrl_issue;
  import alu_pkg::*;

  localparam int unsigned CNT_W = 2;
  localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;
  localparam int NPAT = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;

  alu_ctrl_issue_if #(.CNT_W(CNT_W)) bus ();

  alu_ctrl_issue #(.CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0] op;
    logic       imm;
    logic       br;
    logic       ill;
  } exp_t;

  exp_t        q[$];
  int unsigned mcnt = 0;

  // Legal instruction patterns: (instr & mask) == match -> {opcode, op2_imm, is_branch}
  logic [31:0] pm [NPAT] = '{32'hfe00707f, 32'hfe00707f, 32'hfe00707f, 32'hfe00707f,
                             32'hfe00707f, 32'hfe00707f, 32'h0000707f, 32'h0000707f,
                             32'h0000707f, 32'hfe00707f, 32'hfe00707f, 32'h0000007f,
                             32'h0000007f, 32'h0000707f, 32'h0000707f};
  logic [31:0] pv [NPAT] = '{32'h00000033, 32'h40000033, 32'h00001033, 32'h00005033,
                             32'h00006033, 32'h00007033, 32'h00000013, 32'h00007013,
                             32'h00006013, 32'h00001013, 32'h00005013, 32'h00000003,
                             32'h00000023, 32'h00000063, 32'h00001063};
  logic [4:0]  pr [NPAT] = '{5'b001_0_0, 5'b010_0_0, 5'b101_0_0, 5'b110_0_0,
                             5'b100_0_0, 5'b011_0_0, 5'b001_1_0, 5'b011_1_0,
                             5'b100_1_0, 5'b101_1_0, 5'b110_1_0, 5'b001_1_0,
                             5'b001_1_0, 5'b010_0_1, 5'b010_0_1};

  function automatic exp_t ref_decode(logic [31:0] ins);
    exp_t e;
    e = '{op: 3'b000, imm: 1'b0, br: 1'b0, ill: 1'b1};
    for (int i = 0; i < NPAT; i++) begin
      if ((ins & pm[i]) == pv[i]) begin
        e = '{op: pr[i][4:2], imm: pr[i][1], br: pr[i][0], ill: 1'b0};
        break;
      end
    end
    return e;
  endfunction

  function automatic logic [31:0] gen_instr();
    logic [31:0] w;
    w = $urandom();
    case ($urandom_range(0, 6))
      0: w[6:0] = 7'b0110011;
      1: w[6:0] = 7'b0110011;
      2: w[6:0] = 7'b0010011;
      3: w[6:0] = 7'b0000011;
      4: w[6:0] = 7'b0100011;
      5: w[6:0] = 7'b1100011;
      default: ;
    endcase
    case ($urandom_range(0, 3))
      0, 1: w[31:25] = 7'h00;
      2:    w[31:25] = 7'h20;
      default: ;
    endcase
    return w;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    chk({tag, ".in_ready"}, 32'(bus.in_ready), 32'(!rst && q.size() < 2));
    chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'(q.size() > 0));
    if (q.size() > 0) begin
      chk({tag, ".opcode"}, 32'(bus.alu_opcode), 32'(q[0].op));
      chk({tag, ".op2_imm"}, 32'(bus.op2_imm), 32'(q[0].imm));
      chk({tag, ".is_branch"}, 32'(bus.is_branch), 32'(q[0].br));
      chk({tag, ".illegal"}, 32'(bus.illegal), 32'(q[0].ill));
    end
    chk({tag, ".illegal_cnt"}, 32'(bus.illegal_cnt), mcnt);
  endtask

  // One clock: drive inputs, advance past the edge, update the reference, check.
  task automatic cycle(input logic iv, input logic [31:0] ins, input logic ordy,
                       input string tag);
    logic in_x;
    logic out_x;
    bus.in_valid  = iv;
    bus.instr     = ins;
    bus.out_ready = ordy;
    in_x  = iv && !rst && (q.size() < 2);
    out_x = !rst && ordy && (q.size() > 0);
    @(posedge clk);
    #1;
    if (rst) begin
      q.delete();
      mcnt = 0;
    end else begin
      if (out_x) begin
`ifdef ALU_ILLEGAL_CNT_EN
        if (q[0].ill && mcnt < CNT_MAX) mcnt++;
`endif
        void'(q.pop_front());
      end
      if (in_x) q.push_back(ref_decode(ins));
    end
    check_state(tag);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.instr     = '0;
    bus.out_ready = 1'b0;
    rst = 1'b1;

    cycle(1'b0, 32'h0, 1'b0, "reset");
    chk("reset.opcode0", 32'(bus.alu_opcode), 32'd0);
    chk("reset.flags0", {29'd0, bus.op2_imm, bus.is_branch, bus.illegal}, 32'd0);
    rst = 1'b0;

    cycle(1'b1, 32'h003100B3, 1'b1, "add");
    chk("add.opcode", 32'(bus.alu_opcode), 32'h1);
    chk("add.valid", 32'(bus.out_valid), 32'd1);

    cycle(1'b1, 32'h40B50533, 1'b1, "sub");
    chk("sub.opcode", 32'(bus.alu_opcode), 32'h2);
    cycle(1'b1, 32'h00500293, 1'b1, "addi");
    chk("addi.opcode", 32'(bus.alu_opcode), 32'h1);
    chk("addi.imm", 32'(bus.op2_imm), 32'd1);

    cycle(1'b1, 32'h00208463, 1'b1, "beq");
    chk("beq.opcode", 32'(bus.alu_opcode), 32'h2);
    chk("beq.branch", 32'(bus.is_branch), 32'd1);
    cycle(1'b1, 32'h003140B3, 1'b1, "xor");
    chk("xor.illegal", 32'(bus.illegal), 32'd1);
    chk("xor.opcode", 32'(bus.alu_opcode), 32'd0);
    cycle(1'b1, 32'h403150B3, 1'b1, "sra");
    chk("sra.illegal", 32'(bus.illegal), 32'd1);
    cycle(1'b0, 32'h0, 1'b1, "drain1");

    // Stall with back-to-back valid: two held, third refused.
    cycle(1'b1, 32'h003100B3, 1'b0, "stall1");
    cycle(1'b1, 32'h40B50533, 1'b0, "stall2");
    chk("stall2.in_ready", 32'(bus.in_ready), 32'd0);
    cycle(1'b1, 32'h0020E0B3, 1'b0, "stall3");
    chk("stall3.opcode", 32'(bus.alu_opcode), 32'h1);
    cycle(1'b0, 32'h0, 1'b1, "release1");
    chk("release1.opcode", 32'(bus.alu_opcode), 32'h2);
    cycle(1'b0, 32'h0, 1'b1, "release2");
    chk("release2.empty", 32'(bus.out_valid), 32'd0);

    // Reset with both entries full.
    cycle(1'b1, 32'h003100B3, 1'b0, "fill1");
    cycle(1'b1, 32'h40B50533, 1'b0, "fill2");
    rst = 1'b1;
    cycle(1'b0, 32'h0, 1'b1, "midrst");
    chk("midrst.out_valid", 32'(bus.out_valid), 32'd0);
    rst = 1'b0;
    #1;
    chk("postrst.in_ready", 32'(bus.in_ready), 32'd1);
    chk("postrst.out_valid", 32'(bus.out_valid), 32'd0);

    // Illegal counter saturation.
    for (int i = 0; i < 5; i++) cycle(1'b1, 32'h003140B3, 1'b1, "xcnt");
    cycle(1'b0, 32'h0, 1'b1, "xcnt_last");
`ifdef ALU_ILLEGAL_CNT_EN
    chk("xcnt.sat", 32'(bus.illegal_cnt), CNT_MAX);
`else
    chk("xcnt.zero", 32'(bus.illegal_cnt), 32'd0);
`endif

    // Randomized traffic against the reference queue.
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      cycle($urandom_range(0, 3) != 0, gen_instr(), $urandom_range(0, 2) != 0, "rand");
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 1'b1, "final");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
